// File: rtl/tuple_hash_dispatcher.sv
// tuple_hash_dispatcher
//
// Front end of the partitioned hash join. Hashes the 32-bit join key of each
// 64-bit tuple with the murmur3 32-bit finalizer in a 3-stage stall-able
// pipeline. Build-relation results go to the hash table build port. Once the
// last build tuple has been accepted downstream, a one-cycle start_probing
// pulse is issued. Probe-relation results then go to the probe port.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_tuple/s_valid/s_last/s_ready  input tuple stream (key = s_tuple[31:0])
//   tuple_build/hash_build/
//   input_valid_build/build_ready   build port, with backpressure
//   tuple_probe/hash_probe/
//   input_valid_probe               probe port, no backpressure
//   start_probing                   one-cycle pulse, build phase complete
//   build_count/probe_count         delivered tuple counters (wrapping)
//   done                            probe relation fully delivered (sticky)
module tuple_hash_dispatcher #(
    parameter logic [31:0] SEED      = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          s_tuple,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic [63:0]          tuple_build,
    output logic [31:0]          hash_build,
    output logic                 input_valid_build,
    input  logic                 build_ready,
    output logic [63:0]          tuple_probe,
    output logic [31:0]          hash_probe,
    output logic                 input_valid_probe,
    output logic                 start_probing,
    output logic [CNT_WIDTH-1:0] build_count,
    output logic [CNT_WIDTH-1:0] probe_count,
    output logic                 done
);

    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StBuild, StDrain, StPulse, StProbe, StDone} state_t;

    state_t state_q, state_d;

    // Pipeline stage registers; the probe bit records the phase a tuple
    // entered in so the output is steered to the matching port.
    logic        s1_valid, s1_last, s1_probe;
    logic [63:0] s1_tuple;
    logic [31:0] s1_hash;
    logic        s2_valid, s2_last, s2_probe;
    logic [63:0] s2_tuple;
    logic [31:0] s2_hash;
    logic        s3_valid, s3_last, s3_probe;
    logic [63:0] s3_tuple;
    logic [31:0] s3_hash;

    logic [CNT_WIDTH-1:0] build_count_q, probe_count_q;

    logic        advance, accept, build_xfer;
    logic [31:0] key_x, key_xs, mix1, s1_xs, mix2;

    // Hash datapath; products keep the low 32 bits.
    assign key_x  = s_tuple[31:0] ^ SEED;
    assign key_xs = key_x ^ (key_x >> 16);
    assign mix1   = key_xs * 32'h85EB_CA6B;
    assign s1_xs  = s1_hash ^ (s1_hash >> 13);
    assign mix2   = s1_xs * 32'hC2B2_AE35;

    assign input_valid_build = s3_valid & ~s3_probe;
    assign input_valid_probe = s3_valid & s3_probe;
    assign tuple_build       = s3_tuple;
    assign hash_build        = s3_hash;
    assign tuple_probe       = s3_tuple;
    assign hash_probe        = s3_hash;
    assign build_xfer        = input_valid_build & build_ready;
    assign build_count       = build_count_q;
    assign probe_count       = probe_count_q;
    assign start_probing     = (state_q == StPulse);
    assign done              = (state_q == StDone);
    assign accept            = s_valid & s_ready;

    always_comb begin
        advance = 1'b1;
        s_ready = 1'b0;
        state_d = state_q;
        unique case (state_q)
            StBuild: begin
                advance = ~s3_valid | build_ready;
                s_ready = advance;
                if (accept && s_last) state_d = StDrain;
            end
            StDrain: begin
                advance = ~s3_valid | build_ready;
                if (build_xfer && s3_last) state_d = StPulse;
            end
            StPulse: state_d = StProbe;
            StProbe: begin
                s_ready = 1'b1;
                if (input_valid_probe && s3_last) state_d = StDone;
            end
            StDone: state_d = StDone;
            default: state_d = StBuild;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StBuild;
            build_count_q <= '0;
            probe_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (build_xfer)        build_count_q <= build_count_q + CntOne;
            if (input_valid_probe) probe_count_q <= probe_count_q + CntOne;
        end
    end

    // All stages shift together on advance and hold together otherwise, so a
    // stalled output register never loses or duplicates a tuple.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0; s1_last <= 1'b0; s1_probe <= 1'b0;
            s1_tuple <= '0;   s1_hash <= '0;
            s2_valid <= 1'b0; s2_last <= 1'b0; s2_probe <= 1'b0;
            s2_tuple <= '0;   s2_hash <= '0;
            s3_valid <= 1'b0; s3_last <= 1'b0; s3_probe <= 1'b0;
            s3_tuple <= '0;   s3_hash <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_last  <= s_last;
            s1_probe <= (state_q == StProbe);
            s1_tuple <= s_tuple;
            s1_hash  <= mix1;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_probe <= s1_probe;
            s2_tuple <= s1_tuple;
            s2_hash  <= mix2;
            s3_valid <= s2_valid;
            s3_last  <= s2_last;
            s3_probe <= s2_probe;
            s3_tuple <= s2_tuple;
            s3_hash  <= s2_hash ^ (s2_hash >> 16);
        end
    end

endmodule

// File: tb/tb_tuple_hash_dispatcher.sv
// Self-checking bench for tuple_hash_dispatcher (SEED=0, 4-bit counters).
module tb_tuple_hash_dispatcher;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   s_tuple = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [63:0]   tuple_build, tuple_probe;
    logic [31:0]   hash_build, hash_probe;
    logic          input_valid_build, input_valid_probe;
    logic          build_ready = 1'b1;
    logic          start_probing, done;
    logic [CW-1:0] build_count, probe_count;

    tuple_hash_dispatcher #(
        .SEED      (32'h0000_0000),
        .CNT_WIDTH (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .s_tuple           (s_tuple),
        .s_valid           (s_valid),
        .s_last            (s_last),
        .s_ready           (s_ready),
        .tuple_build       (tuple_build),
        .hash_build        (hash_build),
        .input_valid_build (input_valid_build),
        .build_ready       (build_ready),
        .tuple_probe       (tuple_probe),
        .hash_probe        (hash_probe),
        .input_valid_probe (input_valid_probe),
        .start_probing     (start_probing),
        .build_count       (build_count),
        .probe_count       (probe_count),
        .done              (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] tuple;
        logic [31:0] hash;
        logic        probe;
        logic        last;
        int          cyc;
    } sb_t;

    typedef struct {
        logic [63:0] tuple;
        logic        last;
        logic [31:0] hash;
    } vec_t;

    sb_t         q[$];
    vec_t        vecs[6];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pulses, run, max_run, last_bxfer, last_pxfer;
    logic        exp_probe = 1'b0;
    logic        lat_check = 1'b0;
    logic        done_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_t;
    logic [31:0] prev_h;
    logic [31:0] cur_hash = '0;

    function automatic logic [31:0] ref_hash(input logic [31:0] k);
        logic [31:0] h;
        h = k;
        h = h ^ (h >> 16);
        h = h * 32'h85EB_CA6B;
        h = h ^ (h >> 13);
        h = h * 32'hC2B2_AE35;
        h = h ^ (h >> 16);
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and scoreboard: push on acceptance, pop on each output transfer.
    always @(negedge clk) begin
        sb_t e;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, input_valid_build}, 64'd1);
                chk("stall_tuple", tuple_build, prev_t);
                chk("stall_hash", {32'd0, hash_build}, {32'd0, prev_h});
            end
            chk("port_exclusive", {63'd0, input_valid_build & input_valid_probe}, 64'd0);
            if (input_valid_build && !build_ready)
                chk("s_ready_when_full", {63'd0, s_ready}, 64'd0);
            if ((input_valid_build && build_ready) || input_valid_probe) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tuple %h expected none (cycle %0d)",
                             tuple_build, cyc);
                end else begin
                    e = q.pop_front();
                    chk("out_port_probe", {63'd0, input_valid_probe}, {63'd0, e.probe});
                    chk("out_tuple", tuple_build, e.tuple);
                    chk("out_hash", {32'd0, hash_build}, {32'd0, e.hash});
                    if (lat_check) chk("latency", 64'(cyc - e.cyc), 64'd3);
                    if (e.last) begin
                        if (e.probe) last_pxfer = cyc;
                        else         last_bxfer = cyc;
                    end
                end
            end
            if (input_valid_probe) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (start_probing) begin
                pulses++;
                chk("start_probing_time", 64'(cyc), 64'(last_bxfer + 1));
            end
            if (done && !done_seen) begin
                done_seen = 1'b1;
                chk("done_time", 64'(cyc), 64'(last_pxfer + 1));
            end
            if (s_valid && s_ready) begin
                q.push_back('{tuple: s_tuple, hash: cur_hash, probe: exp_probe,
                              last: s_last, cyc: cyc});
                if (s_last && !exp_probe) exp_probe = 1'b1;
            end
            prev_stall = input_valid_build && !build_ready;
            prev_t     = tuple_build;
            prev_h     = hash_build;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        build_ready = 1'b1;
        q.delete();
        exp_probe = 1'b0;
        prev_stall = 1'b0;
        pulses = 0;
        run = 0;
        max_run = 0;
        done_seen = 1'b0;
        last_bxfer = -100;
        last_pxfer = -100;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Holds the tuple until accepted; returns just after the accepting edge.
    task automatic send(input logic [63:0] t, input logic l, input logic [31:0] h);
        bit ok;
        ok = 1'b0;
        s_tuple = t;
        s_last = l;
        s_valid = 1'b1;
        cur_hash = h;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no s_ready expected acceptance (tuple %h)", t);
        end
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    function automatic logic [63:0] mk_tuple(input int i);
        logic [31:0] k;
        k = $urandom();
        return {16'hBEEF, 16'(i), k};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_valid_build", {63'd0, input_valid_build}, 64'd0);
        chk("rst_valid_probe", {63'd0, input_valid_probe}, 64'd0);
        chk("rst_start_probing", {63'd0, start_probing}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_counts", {56'd0, build_count, probe_count}, 64'd0);
        chk("rst_tuple", tuple_build, 64'd0);
        chk("rst_hash", {32'd0, hash_build}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd1);

        // Table-driven hash vectors, no backpressure
        vecs[0] = '{tuple: 64'h1234_5678_0000_0000, last: 1'b0, hash: 32'h0000_0000};
        vecs[1] = '{tuple: 64'hAAAA_0000_0000_0001, last: 1'b0, hash: 32'h514E_28B7};
        for (int i = 2; i < 6; i++) begin
            t = mk_tuple(i);
            vecs[i] = '{tuple: t, last: (i == 5), hash: ref_hash(t[31:0])};
        end
        do_reset();
        lat_check = 1'b1;
        for (int i = 0; i < 6; i++) send(vecs[i].tuple, vecs[i].last, vecs[i].hash);
        idle();
        wait_cycles(10);
        chk("vec_build_count", {60'd0, build_count}, 64'd6);
        chk("vec_drained", 64'(q.size()), 64'd0);

        // Backpressure: 8 tuples with a 5-cycle stall mid-stream
        do_reset();
        lat_check = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    t = mk_tuple(i);
                    send(t, (i == 7), ref_hash(t[31:0]));
                end
                idle();
            end
            begin
                wait_cycles(4);
                build_ready = 1'b0;
                wait_cycles(5);
                build_ready = 1'b1;
            end
        join
        wait_cycles(12);
        chk("bp_build_count", {60'd0, build_count}, 64'd8);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Phase switch then probe stream
        do_reset();
        lat_check = 1'b1;
        for (int i = 0; i < 4; i++) begin
            t = mk_tuple(i);
            send(t, (i == 3), ref_hash(t[31:0]));
        end
        s_tuple = 64'hDEAD_0000_0000_0000;
        s_last = 1'b0;
        @(negedge clk);
        chk("s_ready_after_last", {63'd0, s_ready}, 64'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            t = mk_tuple(16 + i);
            send(t, (i == 5), ref_hash(t[31:0]));
        end
        idle();
        wait_cycles(10);
        chk("phase_pulses", 64'(pulses), 64'd1);
        chk("phase_build_count", {60'd0, build_count}, 64'd4);
        chk("probe_count", {60'd0, probe_count}, 64'd6);
        chk("probe_run", 64'(max_run), 64'd6);
        chk("done_seen", {63'd0, done_seen}, 64'd1);
        chk("done_level", {63'd0, done}, 64'd1);
        chk("done_s_ready", {63'd0, s_ready}, 64'd0);
        s_valid = 1'b1;
        wait_cycles(3);
        idle();
        wait_cycles(2);
        chk("done_ignores_input", {60'd0, probe_count}, 64'd6);
        chk("probe_drained", 64'(q.size()), 64'd0);

        // Reset with tuples in flight
        do_reset();
        for (int i = 0; i < 3; i++) begin
            t = mk_tuple(i);
            send(t, 1'b0, ref_hash(t[31:0]));
        end
        do_reset();
        @(negedge clk);
        chk("midrst_valid_build", {63'd0, input_valid_build}, 64'd0);
        chk("midrst_valid_probe", {63'd0, input_valid_probe}, 64'd0);
        chk("midrst_counts", {56'd0, build_count, probe_count}, 64'd0);
        chk("midrst_s_ready", {63'd0, s_ready}, 64'd1);
        wait_cycles(6);
        send(64'hAAAA_0000_0000_0001, 1'b1, 32'h514E_28B7);
        idle();
        wait_cycles(8);
        chk("midrst_build_count", {60'd0, build_count}, 64'd1);
        chk("midrst_drained", 64'(q.size()), 64'd0);

        // Counter wrap: 17 builds on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            t = mk_tuple(i);
            send(t, (i == 16), ref_hash(t[31:0]));
        end
        idle();
        wait_cycles(10);
        chk("wrap_build_count", {60'd0, build_count}, 64'd1);
        chk("wrap_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
